// File: rtl/hall_call_register_if.sv
// Event port of hall_call_register: one newly latched hall call per handshake.
// The register drives the master side; the dispatcher/logger is the slave.
interface hall_call_register_if;
  logic       evt_valid;
  logic [3:0] evt_floor;
  logic [1:0] evt_dir;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_floor,
    output evt_dir,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_floor,
    input  evt_dir,
    output evt_ready
  );
endinterface

// File: rtl/hall_call_register.sv
// Hall-call latch for floors 0..10: holds button presses as call levels, clears them on
// arrival, and reports each new call once on a valid/ready event port. Optional filter: HALL_DEBOUNCE_EN.
module hall_call_register #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn0,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic [1:0] btn3,
  input  logic [1:0] btn4,
  input  logic [1:0] btn5,
  input  logic [1:0] btn6,
  input  logic [1:0] btn7,
  input  logic [1:0] btn8,
  input  logic [1:0] btn9,
  input  logic [1:0] btn10,
  input  logic       arr_valid,
  input  logic [3:0] arr_floor,
  input  logic [1:0] arr_dir,
  output logic [1:0] call0,
  output logic [1:0] call1,
  output logic [1:0] call2,
  output logic [1:0] call3,
  output logic [1:0] call4,
  output logic [1:0] call5,
  output logic [1:0] call6,
  output logic [1:0] call7,
  output logic [1:0] call8,
  output logic [1:0] call9,
  output logic [1:0] call10,
  output logic [4:0] pending_cnt,
  hall_call_register_if.master evt
);

  localparam int NB = 22;
  // Bit 2f+1 is floor f up, bit 2f is floor f down; floor 10 up and floor 0 down do not exist.
  localparam logic [NB-1:0] VALID_MASK = 22'h1F_FFFE;

  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 15)) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be within 2..15");
  end

  function automatic logic [4:0] popcount22(input logic [NB-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < NB; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  logic [NB-1:0] btn_raw_s;
  logic [NB-1:0] acc_s;
  logic [NB-1:0] set_s;
  logic [NB-1:0] clr_s;
  logic [NB-1:0] ack_s;
  logic [NB-1:0] btn_q;
  logic [NB-1:0] pend_q;
  logic [NB-1:0] pend_d;
  logic [NB-1:0] unrep_q;
  logic [NB-1:0] unrep_d;
  logic [4:0]    pcnt_q;
  logic [4:0]    pcnt_d;
  logic [3:0]    sel_floor_s;
  logic [1:0]    sel_dir_s;
  logic          evt_valid_s;

  assign btn_raw_s = {btn10, btn9, btn8, btn7, btn6, btn5, btn4, btn3, btn2, btn1, btn0} & VALID_MASK;

`ifdef HALL_DEBOUNCE_EN
  // btn_q holds the filtered level; a change is accepted on the DEBOUNCE_CYCLES-th differing sample.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  logic [3:0] db_cnt_q [NB];
  logic [3:0] db_cnt_d [NB];

  // Counter filter: accepted level and next counter value per button bit.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      if (btn_raw_s[i] != btn_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          acc_s[i]    = btn_raw_s[i];
          db_cnt_d[i] = 4'd0;
        end else begin
          acc_s[i]    = btn_q[i];
          db_cnt_d[i] = db_cnt_q[i] + 4'd1;
        end
      end else begin
        acc_s[i]    = btn_q[i];
        db_cnt_d[i] = 4'd0;
      end
    end
  end

  // Debounce counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end
`else
  assign acc_s = btn_raw_s;
`endif

  // Presented event: lowest floor first, up before down (loop runs downward so the last hit wins).
  always_comb begin
    sel_floor_s = 4'd0;
    sel_dir_s   = 2'b00;
    for (int f = 10; f >= 0; f--) begin
      sel_floor_s = (unrep_q[2*f+1] | unrep_q[2*f]) ? 4'(f) : sel_floor_s;
      sel_dir_s   = unrep_q[2*f+1] ? 2'b10 : (unrep_q[2*f] ? 2'b01 : sel_dir_s);
    end
  end

  assign evt_valid_s   = |unrep_q;
  assign evt.evt_valid = evt_valid_s;
  assign evt.evt_floor = sel_floor_s;
  assign evt.evt_dir   = sel_dir_s;

  // Next state of the call and unreported bits; an arrival clear beats a same-cycle set.
  always_comb begin
    clr_s = 22'd0;
    for (int f = 0; f < 11; f++) begin
      clr_s[2*f +: 2] = (arr_valid && (arr_floor == 4'(f))) ? arr_dir : 2'b00;
    end
    set_s   = acc_s & ~btn_q & ~pend_q & VALID_MASK;
    ack_s   = (evt_valid_s && evt.evt_ready) ? ({20'd0, sel_dir_s} << {sel_floor_s, 1'b0}) : 22'd0;
    pend_d  = (pend_q | set_s) & ~clr_s;
    unrep_d = (unrep_q | set_s) & ~clr_s & ~ack_s;
    pcnt_d  = popcount22(pend_d);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_q   <= 22'd0;
      pend_q  <= 22'd0;
      unrep_q <= 22'd0;
      pcnt_q  <= 5'd0;
    end else begin
      btn_q   <= acc_s;
      pend_q  <= pend_d;
      unrep_q <= unrep_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign {call10, call9, call8, call7, call6, call5, call4, call3, call2, call1, call0} = pend_q;
  assign pending_cnt = pcnt_q;

endmodule
